// File: rtl/game_stage_sequencer.sv
// Round controller for the melody-memory game: generates and loads a melody per stage, starts
// the game module and tracks stage progress. Optional stage timeout under GAME_TIMEOUT_EN.
module game_stage_sequencer #(
    parameter int unsigned N_STAGES      = 3,
    parameter int unsigned TICK_DIV      = 500000,
    parameter int unsigned TIMEOUT_TICKS = 300,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        stage_end,
    input  logic        miss_in,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        game_start,
    output logic        stage_reset,
    output logic [2:0]  stage_idx,
    output logic        busy,
    output logic        all_clear,
    output logic        fail,
    output logic [7:0]  miss_count
);

    if (N_STAGES < 1 || N_STAGES > 8 || SEED == 16'h0 || TICK_DIV == 0 || TIMEOUT_TICKS == 0)
    begin : g_param_check
        $error("game_stage_sequencer: invalid parameter value");
    end

    typedef enum logic [3:0] {
        StIdle, StRstg, StGen, StLoad, StStart, StPlay, StNext, StDone, StFail
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  btn_sync_q;
    logic        btn_prev_q;
    logic        stage_end_q;
    logic        miss_prev_q;
    logic [15:0] lfsr_q, lfsr_d, lfsr_next;
    logic [2:0]  gen_q, gen_d;
    logic        rst_cnt_q, rst_cnt_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  stage_q, stage_d;
    logic [7:0]  miss_q, miss_d;
    logic        start_rise, stage_rise, miss_rise;
    logic        timeout_hit;

    assign start_rise = btn_sync_q[1] & ~btn_prev_q;
    assign stage_rise = stage_end & ~stage_end_q;
    assign miss_rise  = miss_in & ~miss_prev_q;
    assign lfsr_next  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef GAME_TIMEOUT_EN
    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

    logic [PW-1:0] presc_q;
    logic [TW-1:0] tick_q;
    logic          tick_wrap;

    assign tick_wrap = (presc_q == PW'(TICK_DIV - 1));
    // Expire on the wrap that would bring the tick count up to TIMEOUT_TICKS.
    assign timeout_hit = tick_wrap && (tick_q == TW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else if (state_q == StStart) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else if (state_q == StPlay) begin
            if (tick_wrap) begin
                presc_q <= '0;
                tick_q  <= tick_q + TW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            btn_sync_q  <= '0;
            btn_prev_q  <= 1'b0;
            stage_end_q <= 1'b0;
            miss_prev_q <= 1'b0;
            lfsr_q      <= SEED;
            gen_q       <= '0;
            rst_cnt_q   <= 1'b0;
            data_q      <= '0;
            stage_q     <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            btn_sync_q  <= {btn_sync_q[0], start_btn};
            btn_prev_q  <= btn_sync_q[1];
            stage_end_q <= stage_end;
            miss_prev_q <= miss_in;
            lfsr_q      <= lfsr_d;
            gen_q       <= gen_d;
            rst_cnt_q   <= rst_cnt_d;
            data_q      <= data_d;
            stage_q     <= stage_d;
            miss_q      <= miss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        gen_d     = gen_q;
        rst_cnt_d = rst_cnt_q;
        data_d    = data_q;
        stage_d   = stage_q;
        miss_d    = miss_q;

        if (state_q == StPlay && miss_rise && miss_q != 8'hFF) begin
            miss_d = miss_q + 8'd1;
        end

        case (state_q)
            StIdle, StDone, StFail: begin
                if (start_rise) begin
                    state_d = StRstg;
                    stage_d = '0;
                    miss_d  = '0;
                end
            end
            StRstg: begin
                rst_cnt_d = ~rst_cnt_q;
                if (rst_cnt_q) begin
                    state_d = StGen;
                    gen_d   = '0;
                end
            end
            StGen: begin
                lfsr_d = lfsr_next;
                data_d[4*gen_q +: 4] = {1'b0, lfsr_next[2:0]};
                gen_d = gen_q + 3'd1;
                if (gen_q == 3'd7) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StStart;
            StStart: state_d = StPlay;
            StPlay: begin
                if (stage_rise) begin
                    state_d = StNext;
                end else if (timeout_hit) begin
                    state_d = StFail;
                end
            end
            StNext: begin
                if (stage_q == 3'(N_STAGES - 1)) begin
                    state_d = StDone;
                end else begin
                    stage_d = stage_q + 3'd1;
                    state_d = StRstg;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_out     = data_q;
    assign write_enable = (state_q == StLoad);
    assign game_start   = (state_q == StStart);
    assign stage_reset  = (state_q == StRstg);
    assign stage_idx    = stage_q;
    assign busy         = (state_q == StGen) || (state_q == StLoad) || (state_q == StStart) ||
                          (state_q == StPlay) || (state_q == StNext);
    assign all_clear    = (state_q == StDone);
    assign fail         = (state_q == StFail);
    assign miss_count   = miss_q;

endmodule

// File: tb/tb_game_stage_sequencer.sv
// Directed bench for game_stage_sequencer (N_STAGES=2, TICK_DIV=4, TIMEOUT_TICKS=5).
module tb_game_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_btn = 1'b0;
    logic        stage_end = 1'b0;
    logic        miss_in = 1'b0;
    logic [31:0] data_out;
    logic        write_enable, game_start, stage_reset, busy, all_clear, fail;
    logic [2:0]  stage_idx;
    logic [7:0]  miss_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl_lfsr = 16'hACE1;
    logic [31:0] exp_word;
    logic [31:0] load_word;
    logic        load_ok;

    game_stage_sequencer #(
        .N_STAGES      (2),
        .TICK_DIV      (4),
        .TIMEOUT_TICKS (5),
        .SEED          (16'hACE1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (start_btn),
        .stage_end    (stage_end),
        .miss_in      (miss_in),
        .data_out     (data_out),
        .write_enable (write_enable),
        .game_start   (game_start),
        .stage_reset  (stage_reset),
        .stage_idx    (stage_idx),
        .busy         (busy),
        .all_clear    (all_clear),
        .fail         (fail),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference melody: eight LFSR steps, low three bits of each new state per nibble.
    task automatic model_gen();
        logic fb;
        exp_word = '0;
        for (int k = 0; k < 8; k++) begin
            fb = mdl_lfsr[15] ^ mdl_lfsr[13] ^ mdl_lfsr[12] ^ mdl_lfsr[10];
            mdl_lfsr = {mdl_lfsr[14:0], fb};
            exp_word[4*k +: 4] = {1'b0, mdl_lfsr[2:0]};
        end
    endtask

    task automatic wait_load(input bit drop_end);
        load_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (drop_end && stage_reset) stage_end = 1'b0;
            if (write_enable) begin
                load_ok = 1'b1;
                break;
            end
        end
        load_word = data_out;
        model_gen();
    endtask

    task automatic press_start();
        @(negedge clk);
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        mdl_lfsr = 16'hACE1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", data_out); end
        checks++; if ({write_enable, game_start, stage_reset, busy, all_clear, fail} !== 6'b0) begin
            errors++; $display("FAIL rst_flags: got %b want 000000",
                {write_enable, game_start, stage_reset, busy, all_clear, fail}); end
        checks++; if (stage_idx !== 3'd0) begin errors++; $display("FAIL rst_stage: got %0d want 0", stage_idx); end
        checks++; if (miss_count !== 8'd0) begin errors++; $display("FAIL rst_miss: got %0d want 0", miss_count); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_load();
        int n;
        bit found;
        logic [7:0] low;
        start_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stage_reset) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstg_seen: got 0 want 1"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstg_busy: got %b want 0", busy); end
        n = 0;
        while (stage_reset && n < 10) begin n++; @(negedge clk); end
        checks++; if (n != 2) begin errors++; $display("FAIL rstg_len: got %0d want 2", n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gen_busy: got %b want 1", busy); end
        n = 0;
        while (!write_enable && n < 20) begin n++; @(negedge clk); end
        checks++; if (n != 8) begin errors++; $display("FAIL gen_len: got %0d want 8", n); end
        model_gen();
        low = data_out[7:0];
        checks++; if (low !== 8'h73) begin errors++; $display("FAIL load0_low: got %h want 73", low); end
        checks++; if (data_out !== exp_word) begin errors++; $display("FAIL load0_word: got %h want %h", data_out, exp_word); end
        start_btn = 1'b0;
        @(negedge clk);
        checks++; if ({game_start, write_enable} !== 2'b10) begin
            errors++; $display("FAIL start_pulse: got %b want 10", {game_start, write_enable}); end
        @(negedge clk);
        checks++; if ({game_start, busy} !== 2'b01) begin
            errors++; $display("FAIL play_entry: got %b want 01", {game_start, busy}); end
    endtask

    task automatic test_stages();
        bit found;
        checks++; if (stage_idx !== 3'd0) begin errors++; $display("FAIL stg_idx0: got %0d want 0", stage_idx); end
        stage_end = 1'b1;
        wait_load(1'b1);
        checks++; if (!load_ok) begin errors++; $display("FAIL stg_load1: got none want load"); end
        checks++; if (stage_idx !== 3'd1) begin errors++; $display("FAIL stg_idx1: got %0d want 1", stage_idx); end
        checks++; if (load_word !== exp_word) begin errors++; $display("FAIL stg_word1: got %h want %h", load_word, exp_word); end
        repeat (2) @(negedge clk);
        stage_end = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (all_clear) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL done_seen: got 0 want 1"); end
        checks++; if ({busy, fail} !== 2'b00) begin errors++; $display("FAIL done_flags: got %b want 00", {busy, fail}); end
    endtask

    // stage_end left high from the previous game must not count as an edge in the new PLAY.
    task automatic test_stage_end_held();
        bit found;
        press_start();
        wait_load(1'b0);
        checks++; if (load_word !== exp_word) begin errors++; $display("FAIL held_word: got %h want %h", load_word, exp_word); end
        repeat (5) @(negedge clk);
        checks++; if ({busy, stage_reset, stage_idx} !== {2'b10, 3'd0}) begin
            errors++; $display("FAIL held_stay: got %b want 10000", {busy, stage_reset, stage_idx}); end
        stage_end = 1'b0;
        @(negedge clk);
        stage_end = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (stage_reset) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL held_edge: got no stage_reset want one"); end
        stage_end = 1'b0;
    endtask

    task automatic test_miss();
        logic [7:0] exp_miss;
        bit found;
        wait_load(1'b1);
        checks++; if (load_word !== exp_word) begin errors++; $display("FAIL miss_word: got %h want %h", load_word, exp_word); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            miss_in = 1'b1; @(negedge clk);
            miss_in = 1'b0; @(negedge clk);
        end
        checks++; if (miss_count !== 8'd5) begin errors++; $display("FAIL miss_5: got %0d want 5", miss_count); end
        for (int i = 0; i < 295; i++) begin
            miss_in = 1'b1; @(negedge clk);
            miss_in = 1'b0; @(negedge clk);
        end
`ifdef GAME_TIMEOUT_EN
        exp_miss = 8'd10;  // edges stop counting once the 20-cycle PLAY window times out
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL miss_fail: got %b want 1", fail); end
`else
        exp_miss = 8'hFF;
        stage_end = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL miss_done: got %b want 1", all_clear); end
`endif
        checks++; if (miss_count !== exp_miss) begin errors++; $display("FAIL miss_sat: got %h want %h", miss_count, exp_miss); end
        start_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stage_reset) begin found = 1'b1; break; end
        end
        start_btn = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL restart_seen: got 0 want 1"); end
        checks++; if (miss_count !== 8'd0) begin errors++; $display("FAIL restart_miss: got %0d want 0", miss_count); end
        checks++; if (stage_idx !== 3'd0) begin errors++; $display("FAIL restart_idx: got %0d want 0", stage_idx); end
    endtask

    task automatic test_timeout();
        int n;
        wait_load(1'b1);
        checks++; if (load_word !== exp_word) begin errors++; $display("FAIL to_word: got %h want %h", load_word, exp_word); end
        repeat (2) @(negedge clk);
`ifdef GAME_TIMEOUT_EN
        n = 0;
        while (!fail && n < 40) begin n++; @(negedge clk); end
        checks++; if (n != 20) begin errors++; $display("FAIL to_latency: got %0d want 20", n); end
        checks++; if ({busy, all_clear} !== 2'b00) begin errors++; $display("FAIL to_flags: got %b want 00", {busy, all_clear}); end
`else
        repeat (1100) @(negedge clk);
        checks++; if ({busy, fail, stage_idx} !== {2'b10, 3'd0}) begin
            errors++; $display("FAIL to_stay: got %b want 10000", {busy, fail, stage_idx}); end
`endif
    endtask

    task automatic test_same_cycle();
        pulse_reset();
        press_start();
        wait_load(1'b1);
        checks++; if (load_word !== exp_word) begin errors++; $display("FAIL sc_word: got %h want %h", load_word, exp_word); end
        repeat (2) @(negedge clk);
        repeat (19) @(negedge clk);
        stage_end = 1'b1;
        @(negedge clk);
        checks++; if ({fail, busy, stage_reset} !== 3'b010) begin
            errors++; $display("FAIL sc_next: got %b want 010", {fail, busy, stage_reset}); end
        @(negedge clk);
        checks++; if ({stage_reset, stage_idx} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL sc_rstg: got %b want 1001", {stage_reset, stage_idx}); end
        stage_end = 1'b0;
    endtask

    task automatic test_reset_mid_gen();
        logic [7:0] low;
        pulse_reset();
        start_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stage_reset) break;
        end
        while (stage_reset) @(negedge clk);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        start_btn = 1'b0;
        mdl_lfsr = 16'hACE1;
        @(posedge clk);
        #1;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 0", data_out); end
        checks++; if ({write_enable, game_start, stage_reset, busy, all_clear, fail, stage_idx, miss_count} !== 17'b0) begin
            errors++; $display("FAIL mid_flags: got %b want 0",
                {write_enable, game_start, stage_reset, busy, all_clear, fail, stage_idx, miss_count}); end
        @(negedge clk);
        reset = 1'b1;
        press_start();
        wait_load(1'b1);
        low = load_word[7:0];
        checks++; if (!load_ok) begin errors++; $display("FAIL mid_load: got none want load"); end
        checks++; if (low !== 8'h73) begin errors++; $display("FAIL mid_low: got %h want 73", low); end
        checks++; if (load_word !== exp_word) begin errors++; $display("FAIL mid_word: got %h want %h", load_word, exp_word); end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_stages();
        test_stage_end_held();
        test_miss();
        test_timeout();
        test_same_cycle();
        test_reset_mid_gen();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
